// File: rtl/dmem_arb_pkg.sv
// Shared types and address map for the MEM-stage data RAM arbiter.
// Owner tags travel with in-flight reads; the range constants serve upstream decode.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [31:0] RAM_LIMIT  = 32'h3000_0000;
    localparam logic [31:0] ROM_BASE   = 32'h3000_0000;
    localparam logic [31:0] ROM_LIMIT  = 32'h4000_0000;
    localparam logic [31:0] MMIO_BASE  = 32'h4000_0000;
    localparam logic [31:0] MMIO_LIMIT = 32'h4000_0014;

    function automatic logic is_ram(input logic [31:0] a);
        return a < RAM_LIMIT;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU port, DMA port and RAM port signals of the data RAM arbiter.
// The arbiter is the slave; requesters plus the RAM sit on the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8
);

    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [31:0]       dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/dmem_starve_timer.sv
// Counts consecutive denied DMA cycles and forces DMA ahead of the CPU
// once the count reaches MAX_WAIT.
module dmem_starve_timer #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_req_i,
    input  logic dma_gnt_i,
    output logic force_o
);

    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] MAX_W = W'(MAX_WAIT);

    logic [W-1:0] wait_q, wait_d;

    always_comb begin
        wait_d = wait_q;
        if (!dma_req_i || dma_gnt_i) begin
            wait_d = '0;
        end else if (wait_q != MAX_W) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign force_o = dma_req_i & (wait_q == MAX_W);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the MEM stage (CPU) and the DMA loader.
// One grant per cycle, 1-cycle read return tagged by owner, starvation guard for DMA.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic [CNT_W-1:0] stall_cnt
);

    logic   force_d;
    logic   gnt_c, gnt_d;
    owner_e rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    dmem_starve_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .dma_req_i (bus.dma_req),
        .dma_gnt_i (gnt_d),
        .force_o   (force_d)
    );

    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (!reset) begin
            if (force_d) begin
                gnt_d = 1'b1;
            end else if (bus.cpu_req) begin
                gnt_c = 1'b1;
            end else if (bus.dma_req) begin
                gnt_d = 1'b1;
            end
        end
    end

    assign bus.cpu_stall = bus.cpu_req & ~gnt_c & ~reset;
    assign bus.dma_gnt   = gnt_d;

    assign bus.ram_en    = gnt_c | gnt_d;
    assign bus.ram_we    = gnt_d ? bus.dma_we : (gnt_c & bus.cpu_we);
    assign bus.ram_addr  = gnt_d ? bus.dma_addr[ADDR_W+1:2]
                                 : bus.cpu_addr[ADDR_W+1:2];
    assign bus.ram_wdata = gnt_d ? bus.dma_wdata : bus.cpu_wdata;

    wire unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0],
                              bus.dma_addr[31:ADDR_W+2], bus.dma_addr[1:0]};

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (gnt_c && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (gnt_d && !bus.dma_we) begin
            rd_owner_d = OWN_DMA;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cpu_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q  <= OWN_NONE;
            stall_cnt_q <= '0;
        end else begin
            rd_owner_q  <= rd_owner_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A read in flight when reset arrives is dropped, not returned.
    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU) & ~reset;
    assign bus.dma_rvalid = (rd_owner_q == OWN_DMA) & ~reset;
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.dma_rdata  = bus.ram_rdata;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a
// transaction-level model of grants, read returns and stall statistics.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    logic [31:0] ram [256];
    logic [31:0] ram_q = '0;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                ram[bus.ram_addr] <= bus.ram_wdata;
                ram_q <= bus.ram_wdata;
            end else begin
                ram_q <= ram[bus.ram_addr];
            end
        end
    end
    assign bus.ram_rdata = ram_q;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem [256];
    int          m_run = 0;
    int          m_own = 0;
    logic [31:0] m_data = '0;
    int          m_stalls = 0;
    bit          m_inited = 0;
    bit          last_gc, last_gd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic creq, input logic cwe,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dreq, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dd);
        bit frc, gc, gd, stl;
        int exp_cnt;
        @(posedge clk);
        #1;
        reset = rst;
        bus.cpu_req = creq; bus.cpu_we = cwe;
        bus.cpu_addr = ca;  bus.cpu_wdata = cd;
        bus.dma_req = dreq; bus.dma_we = dwe;
        bus.dma_addr = da;  bus.dma_wdata = dd;
        #3;
        frc = !rst && dreq && (m_run >= MAX_WAIT);
        gd  = frc || (!rst && !creq && dreq);
        gc  = !rst && creq && !frc;
        stl = !rst && creq && !gc;
        check("ram_en", 32'(bus.ram_en), 32'(gc | gd));
        check("cpu_stall", 32'(bus.cpu_stall), 32'(stl));
        check("dma_gnt", 32'(bus.dma_gnt), 32'(gd));
        if (gc) begin
            check("ram_we_c", 32'(bus.ram_we), 32'(cwe));
            check("ram_addr_c", 32'(bus.ram_addr), 32'(ca[9:2]));
            if (cwe) check("ram_wdata_c", bus.ram_wdata, cd);
        end
        if (gd) begin
            check("ram_we_d", 32'(bus.ram_we), 32'(dwe));
            check("ram_addr_d", 32'(bus.ram_addr), 32'(da[9:2]));
            if (dwe) check("ram_wdata_d", bus.ram_wdata, dd);
        end
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!rst && m_own == 1));
        check("dma_rvalid", 32'(bus.dma_rvalid), 32'(!rst && m_own == 2));
        if (!rst && m_own == 1) check("cpu_rdata", bus.cpu_rdata, m_data);
        if (!rst && m_own == 2) check("dma_rdata", bus.dma_rdata, m_data);
        if (m_inited) begin
            exp_cnt = (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls;
            check("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
        end
        last_gc = gc;
        last_gd = gd;
        if (rst) begin
            m_run = 0; m_own = 0; m_stalls = 0; m_inited = 1;
        end else begin
            m_run = (dreq && !gd) ? m_run + 1 : 0;
            if (stl) m_stalls++;
            m_own = 0;
            if (gc) begin
                if (cwe) m_mem[ca[9:2]] = cd;
                else begin m_own = 1; m_data = m_mem[ca[9:2]]; end
            end
            if (gd) begin
                if (dwe) m_mem[da[9:2]] = dd;
                else begin m_own = 2; m_data = m_mem[da[9:2]]; end
            end
        end
    endtask

    bit          c_pend = 0, d_pend = 0;
    logic        c_we, d_we;
    logic [31:0] c_a, c_d, d_a, d_d;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
            m_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
        end
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;

        step(1, 0,0,0,0, 0,0,0,0);
        step(1, 1,0,32'h10,0, 1,0,32'h14,0);
        check("rst_ram_en", 32'(bus.ram_en), 0);
        step(0, 0,0,0,0, 0,0,0,0);
        check("rst_cnt", 32'(stall_cnt), 0);

        step(0, 1,0,32'h10,0, 0,0,0,0);
        check("t1_addr", 32'(bus.ram_addr), 4);
        check("t1_stall", 32'(bus.cpu_stall), 0);
        step(0, 0,0,0,0, 0,0,0,0);
        check("t1_rvalid", 32'(bus.cpu_rvalid), 1);
        check("t1_rdata", bus.cpu_rdata, 32'hC4DA_0404);

        step(0, 1,0,32'h18,0, 1,0,32'h1C,0);
        check("t2_stall", 32'(bus.cpu_stall), 0);
        check("t2_gnt", 32'(bus.dma_gnt), 0);
        step(0, 0,0,0,0, 1,0,32'h1C,0);
        check("t2_gnt2", 32'(bus.dma_gnt), 1);
        step(0, 0,0,0,0, 0,0,0,0);

        for (int i = 0; i < 5; i++) begin
            step(0, 1,0,32'h40,0, 1,1,32'h80,32'h1111_2222);
            if (i < 4) begin
                check("t3_denied", 32'(bus.dma_gnt), 0);
            end else begin
                check("t3_forced", 32'(bus.dma_gnt), 1);
                check("t3_stall", 32'(bus.cpu_stall), 1);
            end
        end
        step(0, 1,0,32'h40,0, 1,0,32'h84,0);
        check("t3_cnt", 32'(stall_cnt), 1);
        check("t3_reset_wait", 32'(bus.dma_gnt), 0);
        step(0, 0,0,0,0, 0,0,0,0);

        step(0, 0,0,0,0, 1,1,32'h20,32'hDEAD_BEEF);
        step(0, 1,0,32'h20,0, 0,0,0,0);
        step(0, 0,0,0,0, 0,0,0,0);
        check("t4_raw", bus.cpu_rdata, 32'hDEAD_BEEF);

        step(0, 1,0,32'h30,0, 0,0,0,0);
        step(1, 0,0,0,0, 0,0,0,0);
        check("t5_rvalid", 32'(bus.cpu_rvalid), 0);
        check("t5_en", 32'(bus.ram_en), 0);
        step(0, 0,0,0,0, 0,0,0,0);
        check("t5_cnt", 32'(stall_cnt), 0);
        check("t5_rvalid2", 32'(bus.cpu_rvalid), 0);

        for (int i = 0; i < 120; i++) begin
            step(0, 1,0,32'h44,0, 1,0,32'h48,0);
        end
        step(0, 0,0,0,0, 0,0,0,0);
        check("t6_sat", 32'(stall_cnt), CNT_MAX);

        step(1, 0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            if (!c_pend && $urandom_range(0, 3) != 0) begin
                c_pend = 1; c_we = 1'($urandom);
                c_a = {22'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 2'($urandom)};
                c_d = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; d_we = 1'($urandom);
                d_a = {22'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 2'($urandom)};
                d_d = $urandom;
            end
            step(($urandom_range(0, 60) == 0),
                 c_pend, c_we, c_a, c_d, d_pend, d_we, d_a, d_d);
            if (last_gc) c_pend = 0;
            if (last_gd) d_pend = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
